sample_buffer_reader: RTL and testbench



---
 rtl/sample_buffer_pkg.sv | 28 ++
 rtl/sample_buffer_reader_if.sv | 28 ++
 rtl/frame_checksum_acc.sv | 26 ++
 rtl/sample_buffer_reader.sv | 192 +++++++++++++++++++
 tb/tb_sample_buffer_reader.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_buffer_pkg.sv
// Shared constants and types for the sample buffer readout blocks.
//   NUM_CHANNELS / DEPTH : buffer geometry (channels, samples per channel)
//   SAMPLE_BITS          : sample and stream byte width
//   HEADER / CHID_PREFIX : frame start byte and channel ID prefix
//   CHAN_W / IDX_W       : widths of the buffer read channel and index
//   reader_state_e       : readout FSM states
package sample_buffer_pkg;

    localparam int unsigned NUM_CHANNELS = 7;
    localparam int unsigned SAMPLE_BITS  = 8;
    localparam int unsigned DEPTH        = 10;
    localparam int unsigned CHAN_W       = 3;
    localparam int unsigned IDX_W        = 4;

    localparam logic [SAMPLE_BITS-1:0] HEADER      = 8'hA5;
    localparam logic [SAMPLE_BITS-1:0] CHID_PREFIX = 8'hC0;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StChid,
        StFetch,
        StSamp,
        StCsum,
        StFin
    } reader_state_e;

endpackage

// File: rtl/sample_buffer_reader_if.sv
// Bus bundle between the readout engine and its environment.
//   rd_en/rd_chan/rd_idx : buffer read request (master drives)
//   rd_data              : buffer read data, valid one cycle after rd_en (slave drives)
//   out_data/out_valid/out_last : framed byte stream (master drives)
//   out_ready            : stream sink ready (slave drives)
interface sample_buffer_reader_if;
    import sample_buffer_pkg::*;

    logic                   rd_en;
    logic [CHAN_W-1:0]      rd_chan;
    logic [IDX_W-1:0]       rd_idx;
    logic [SAMPLE_BITS-1:0] rd_data;
    logic [SAMPLE_BITS-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;

    modport master (
        output rd_en, rd_chan, rd_idx, out_data, out_valid, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_chan, rd_idx, out_data, out_valid, out_last,
        output rd_data, out_ready
    );

endinterface

// File: rtl/frame_checksum_acc.sv
// 8-bit modulo-256 running sum for framed byte streams.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the sum (wins over add)
//   add        : add data to the sum on this clock edge
//   data       : byte to add
//   sum        : current accumulated value
module frame_checksum_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (add) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/sample_buffer_reader.sv
// Readout engine: on start, emits header, then for each enabled channel an ID byte and
// its samples oldest-first, then a modulo-256 checksum of all preceding bytes.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle frame request (ignored unless idle)
//   chan_mask  : enabled channels, latched on the accepted start
//   bus        : buffer read port and output byte stream
//   busy       : frame in progress
//   done       : one-cycle pulse after the checksum byte transfers
module sample_buffer_reader
    import sample_buffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_CHANNELS-1:0] chan_mask,
    sample_buffer_reader_if.master  bus,
    output logic                    busy,
    output logic                    done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    reader_state_e           state;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [CHAN_W-1:0]       ch_q;
    logic [IDX_W-1:0]        idx_q;
    logic [SAMPLE_BITS-1:0]  data_q;
    logic                    fresh_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic                    rd_en_q;
    logic [CHAN_W-1:0]       rd_chan_q;
    logic [IDX_W-1:0]        rd_idx_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    hs;
    logic [SAMPLE_BITS-1:0]  out_byte;
    logic [SAMPLE_BITS-1:0]  csum;
    logic [CHAN_W:0]         first_ch;
    logic [CHAN_W:0]         above_ch;

    // Lowest enabled channel at or above 'from'; MSB of the result flags a hit.
    function automatic logic [CHAN_W:0] next_chan(input logic [NUM_CHANNELS-1:0] mask,
                                                  input int from);
        logic [CHAN_W:0] r;
        r = '0;
        for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
            if (mask[i] && i >= from) begin
                r = {1'b1, CHAN_W'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [SAMPLE_BITS-1:0] chid_byte(input logic [CHAN_W-1:0] c);
        return CHID_PREFIX | {{(SAMPLE_BITS - CHAN_W){1'b0}}, c};
    endfunction

    assign first_ch = next_chan(mask_q, 0);
    assign above_ch = next_chan(mask_q, int'(ch_q) + 1);
    assign hs       = out_valid_q && bus.out_ready;

    // rd_data only arrives in the first SAMP cycle, so it is forwarded straight through
    // then and held in data_q for any stall. The checksum byte reads the accumulator,
    // which already holds the sum of everything before it.
    always_comb begin
        out_byte = data_q;
        if (state == StCsum) begin
            out_byte = csum;
        end else if (fresh_q) begin
            out_byte = bus.rd_data;
        end
    end

    frame_checksum_acc u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state == StIdle) && start),
        .add   (hs),
        .data  (out_byte),
        .sum   (csum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            mask_q      <= '0;
            ch_q        <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            fresh_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_chan_q   <= '0;
            rd_idx_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            fresh_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        mask_q      <= chan_mask;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        data_q      <= HEADER;
                        state       <= StHdr;
                    end
                end
                StHdr: begin
                    if (hs) begin
                        if (first_ch[CHAN_W]) begin
                            ch_q   <= first_ch[CHAN_W-1:0];
                            data_q <= chid_byte(first_ch[CHAN_W-1:0]);
                            state  <= StChid;
                        end else begin
                            out_last_q <= 1'b1;
                            state      <= StCsum;
                        end
                    end
                end
                StChid: begin
                    if (hs) begin
                        out_valid_q <= 1'b0;
                        idx_q       <= '0;
                        rd_en_q     <= 1'b1;
                        rd_chan_q   <= ch_q;
                        rd_idx_q    <= '0;
                        state       <= StFetch;
                    end
                end
                StFetch: begin
                    out_valid_q <= 1'b1;
                    fresh_q     <= 1'b1;
                    state       <= StSamp;
                end
                StSamp: begin
                    if (fresh_q) begin
                        data_q <= bus.rd_data;
                    end
                    if (hs) begin
                        if (idx_q != LAST_IDX) begin
                            idx_q       <= idx_q + 1'b1;
                            out_valid_q <= 1'b0;
                            rd_en_q     <= 1'b1;
                            rd_chan_q   <= ch_q;
                            rd_idx_q    <= idx_q + 1'b1;
                            state       <= StFetch;
                        end else if (above_ch[CHAN_W]) begin
                            ch_q   <= above_ch[CHAN_W-1:0];
                            data_q <= chid_byte(above_ch[CHAN_W-1:0]);
                            state  <= StChid;
                        end else begin
                            out_last_q <= 1'b1;
                            state      <= StCsum;
                        end
                    end
                end
                StCsum: begin
                    if (hs) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state       <= StFin;
                    end
                end
                StFin: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.out_data  = out_byte;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_chan   = rd_chan_q;
    assign bus.rd_idx    = rd_idx_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_sample_buffer_reader.sv
// Self-checking bench for sample_buffer_reader: a buffer memory model answers reads one
// cycle after rd_en, and every frame is compared with a frame built directly from the
// mask and memory contents.
module tb_sample_buffer_reader;
    import sample_buffer_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [NUM_CHANNELS-1:0] chan_mask = '0;
    logic                    busy;
    logic                    done;

    sample_buffer_reader_if bus ();

    sample_buffer_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .chan_mask (chan_mask),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [NUM_CHANNELS][DEPTH];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_chan][bus.rd_idx];
    end

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    logic       got_last_q[$];
    logic [6:0] rd_q[$];
    logic [7:0] exp_q[$];
    logic [6:0] exp_rd_q[$];
    int         stall_seen;
    int         stall_viol;
    bit         timeout;

    // mode 0: ch0 = 01..0A, rest random; 1: all zero; 2: all random
    task automatic fill_mem(input int mode);
        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                case (mode)
                    0:       mem[c][i] = (c == 0) ? 8'(i + 1) : 8'($urandom_range(0, 255));
                    1:       mem[c][i] = 8'h00;
                    default: mem[c][i] = 8'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    // Frame straight from the framing rules: header, per enabled channel the ID byte and
    // all samples oldest-first, then the byte sum of all of those modulo 256.
    task automatic build_expected(input logic [NUM_CHANNELS-1:0] m);
        int s;
        exp_q.delete();
        exp_rd_q.delete();
        exp_q.push_back(8'hA5);
        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
            if (m[c]) begin
                exp_q.push_back(8'hC0 + 8'(c));
                for (int i = 0; i < int'(DEPTH); i++) begin
                    exp_q.push_back(mem[c][i]);
                    exp_rd_q.push_back({3'(c), 4'(i)});
                end
            end
        end
        s = 0;
        foreach (exp_q[k]) s += int'(exp_q[k]);
        exp_q.push_back(8'(s % 256));
    endtask

    // Drives one frame and records transfers, reads and stall behaviour.
    // ready_mode 0: always ready; 1: 1,0,0,1 repeating; 2: random.
    task automatic run_frame(input logic [NUM_CHANNELS-1:0] m, input int ready_mode,
                             input int extra_start_at, input bit start_in_fin);
        int         cyc;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        got_q.delete();
        got_last_q.delete();
        rd_q.delete();
        stall_seen = 0;
        stall_viol = 0;
        timeout    = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        @(negedge clk);
        chan_mask     = m;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            start     = 1'b0;
            chan_mask = 7'($urandom_range(0, 127));
            if (cyc == extra_start_at) start = 1'b1;
            if (start_in_fin && done) start = 1'b1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (prev_stall) begin
                stall_seen++;
                if (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last)
                    stall_viol++;
            end
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_data);
                got_last_q.push_back(bus.out_last);
            end
            if (bus.rd_en) rd_q.push_back({bus.rd_chan, bus.rd_idx});
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            if (done) break;
            cyc++;
            if (cyc > 3000) begin
                timeout = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.out_valid, bus.out_last, bus.rd_en, busy, done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%05b exp=00000",
                     {bus.out_valid, bus.out_last, bus.rd_en, busy, done});
        end
        total++;
        if (bus.out_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data got=%02h exp=00", bus.out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty_mask;
        fill_mem(2);
        build_expected('0);
        run_frame('0, 0, -1, 1'b0);
        total++;
        if (timeout) begin bad++; $display("FAIL empty timeout got=1 exp=0"); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL empty len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL empty byte[%0d] got=%02h/%0b exp=%02h/%0b", i, got_q[i],
                         got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        total++;
        if (rd_q.size() != 0) begin
            bad++;
            $display("FAIL empty rd_en_count got=%0d exp=0", rd_q.size());
        end
    endtask

    task automatic test_single_channel;
        fill_mem(0);
        build_expected(7'b0000001);
        run_frame(7'b0000001, 0, -1, 1'b0);
        total++;
        if (timeout) begin bad++; $display("FAIL single timeout got=1 exp=0"); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL single len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL single byte[%0d] got=%02h/%0b exp=%02h/%0b", i, got_q[i],
                         got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        total++;
        if (got_q.size() == 0 || got_q[got_q.size() - 1] !== 8'h9C) begin
            bad++;
            $display("FAIL single csum got=%02h exp=9c",
                     got_q.size() ? got_q[got_q.size() - 1] : 8'h00);
        end
        total++;
        if (rd_q != exp_rd_q) begin
            bad++;
            $display("FAIL single rd_seq got_n=%0d exp_n=%0d", rd_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic test_sparse;
        fill_mem(1);
        build_expected(7'b0100100);
        run_frame(7'b0100100, 0, -1, 1'b0);
        total++;
        if (timeout) begin bad++; $display("FAIL sparse timeout got=1 exp=0"); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL sparse len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL sparse byte[%0d] got=%02h/%0b exp=%02h/%0b", i, got_q[i],
                         got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        total++;
        if (got_q.size() == 0 || got_q[got_q.size() - 1] !== 8'h2C) begin
            bad++;
            $display("FAIL sparse csum got=%02h exp=2c",
                     got_q.size() ? got_q[got_q.size() - 1] : 8'h00);
        end
        total++;
        if (rd_q != exp_rd_q) begin
            bad++;
            $display("FAIL sparse rd_seq got_n=%0d exp_n=%0d", rd_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic test_backpressure;
        fill_mem(0);
        build_expected(7'b0000001);
        run_frame(7'b0000001, 1, -1, 1'b0);
        total++;
        if (timeout) begin bad++; $display("FAIL bp timeout got=1 exp=0"); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL bp len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL bp byte[%0d] got=%02h/%0b exp=%02h/%0b", i, got_q[i],
                         got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        total++;
        if (stall_seen == 0 || stall_viol != 0) begin
            bad++;
            $display("FAIL bp stall_hold got_viol=%0d stalls=%0d exp_viol=0", stall_viol,
                     stall_seen);
        end
    endtask

    task automatic test_start_while_busy;
        int extra;
        fill_mem(2);
        build_expected(7'b1000001);
        run_frame(7'b1000001, 0, 30, 1'b1);
        total++;
        if (timeout) begin bad++; $display("FAIL busy_start timeout got=1 exp=0"); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL busy_start len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL busy_start byte[%0d] got=%02h/%0b exp=%02h/%0b", i, got_q[i],
                         got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid || busy || bus.rd_en) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL busy_start second_frame got=%0d active cycles exp=0", extra);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit found;
        fill_mem(2);
        @(negedge clk);
        chan_mask     = 7'b0000001;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (bus.rd_en && bus.rd_idx == 4'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!found) begin bad++; $display("FAIL rst_mid reach_idx4 got=0 exp=1"); end
        @(negedge clk);
        total++;
        if ({bus.out_valid, busy} !== 2'b11) begin
            bad++;
            $display("FAIL rst_mid in_samp got=%02b exp=11", {bus.out_valid, busy});
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, busy, done, bus.rd_en, bus.out_last} !== 5'b0) begin
            bad++;
            $display("FAIL rst_mid async_clear got=%05b exp=00000",
                     {bus.out_valid, busy, done, bus.rd_en, bus.out_last});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_mem(2);
        build_expected(7'b0000001);
        run_frame(7'b0000001, 0, -1, 1'b0);
        total++;
        if (timeout) begin bad++; $display("FAIL rst_mid timeout got=1 exp=0"); end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rst_mid len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL rst_mid byte[%0d] got=%02h/%0b exp=%02h/%0b", i, got_q[i],
                         got_last_q[i], exp_q[i], i == exp_q.size() - 1);
            end
        end
    endtask

    task automatic test_random_frames;
        logic [NUM_CHANNELS-1:0] m;
        for (int f = 0; f < 5; f++) begin
            fill_mem(2);
            m = 7'($urandom_range(0, 127));
            build_expected(m);
            run_frame(m, 2, -1, 1'b0);
            total++;
            if (timeout) begin bad++; $display("FAIL rand%0d timeout got=1 exp=0", f); end
            total++;
            if (got_q.size() != exp_q.size()) begin
                bad++;
                $display("FAIL rand%0d len got=%0d exp=%0d mask=%07b", f, got_q.size(),
                         exp_q.size(), m);
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) begin
                    bad++;
                    $display("FAIL rand%0d byte[%0d] got=%02h/%0b exp=%02h/%0b", f, i,
                             got_q[i], got_last_q[i], exp_q[i], i == exp_q.size() - 1);
                end
            end
            total++;
            if (rd_q != exp_rd_q || stall_viol != 0) begin
                bad++;
                $display("FAIL rand%0d rd_seq_or_stall got_n=%0d exp_n=%0d viol=%0d", f,
                         rd_q.size(), exp_rd_q.size(), stall_viol);
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty_mask();
        test_single_channel();
        test_sparse();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_frame();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
